// File: rtl/b2_serial_integer_comparator.sv
// Digit-serial N-bit comparator: borrow-chained subtraction, K bits per clock, soc/eoc handshake.
// Optional macro COMPARATOR_MINMAX_EN adds registered min_out/max_out outputs.
module b2_serial_integer_comparator #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  output logic         eoc,
  input  logic         signed_mode,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         flag_eq,
  output logic         flag_gr,
  output logic         flag_lr
`ifdef COMPARATOR_MINMAX_EN
  ,
  output logic [N-1:0] min_out,
  output logic [N-1:0] max_out
`endif
);

  localparam int DIGITS = N / K;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if ((N < 2) || (K < 1) || (K > N) || ((N % K) != 0)) begin : g_bad_params
      $error("b2_serial_integer_comparator: illegal N/K combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  x_sh, y_sh;
  logic          borrow, zero, sm_q, xm, ym;
  logic [CW-1:0] cnt;

  logic [K:0] dig_diff;
  logic       borrow_nxt, zero_nxt, last_digit, lr_nxt;

`ifdef COMPARATOR_MINMAX_EN
  logic [N-1:0] x_q, y_q;
`endif

  // One digit of the subtraction; the extra top bit of dig_diff is the borrow out.
  always_comb begin
    dig_diff   = {1'b0, x_sh[K-1:0]} - {1'b0, y_sh[K-1:0]} - {{K{1'b0}}, borrow};
    borrow_nxt = dig_diff[K];
    zero_nxt   = zero & (dig_diff[K-1:0] == '0);
    last_digit = (cnt == CW'(DIGITS - 1));
    lr_nxt     = sm_q ? ((xm & ~ym) | (~(xm ^ ym) & borrow_nxt)) : borrow_nxt;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (soc)        state_nxt = S_CALC;
      S_CALC:  if (last_digit) state_nxt = S_WAIT;
      S_WAIT:  if (!soc)       state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  assign eoc = (state == S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      x_sh    <= '0;
      y_sh    <= '0;
      borrow  <= 1'b0;
      zero    <= 1'b0;
      sm_q    <= 1'b0;
      xm      <= 1'b0;
      ym      <= 1'b0;
      cnt     <= '0;
      flag_eq <= 1'b0;
      flag_gr <= 1'b0;
      flag_lr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (soc) begin
            x_sh   <= x;
            y_sh   <= y;
            sm_q   <= signed_mode;
            xm     <= x[N-1];
            ym     <= y[N-1];
            borrow <= 1'b0;
            zero   <= 1'b1;
            cnt    <= '0;
          end
        end
        S_CALC: begin
          x_sh   <= x_sh >> K;
          y_sh   <= y_sh >> K;
          borrow <= borrow_nxt;
          zero   <= zero_nxt;
          cnt    <= cnt + CW'(1);
          if (last_digit) begin
            flag_eq <= zero_nxt;
            flag_lr <= lr_nxt;
            flag_gr <= ~zero_nxt & ~lr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COMPARATOR_MINMAX_EN
  // Full operand copies are kept because the shift registers are consumed by the subtraction.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      x_q     <= '0;
      y_q     <= '0;
      min_out <= '0;
      max_out <= '0;
    end else begin
      if (state == S_IDLE && soc) begin
        x_q <= x;
        y_q <= y;
      end
      if (state == S_CALC && last_digit) begin
        min_out <= lr_nxt ? x_q : y_q;
        max_out <= lr_nxt ? y_q : x_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_b2_serial_integer_comparator.sv
// Self-checking bench for b2_serial_integer_comparator: directed and random operations on N=8/K=2,
// plus a K sweep {1,2,4,8}; compares against a plain-arithmetic reference model.
module tb_b2_serial_integer_comparator;

  localparam int N = 8;
  localparam int K = 2;
  localparam int D = N / K;

  logic         clock = 1'b0;
  logic         reset_;
  logic         soc, signed_mode;
  logic [N-1:0] x, y;
  logic         eoc, flag_eq, flag_gr, flag_lr;
`ifdef COMPARATOR_MINMAX_EN
  logic [N-1:0] min_out, max_out;
`endif

  logic         soc_s, sm_s;
  logic [N-1:0] x_s, y_s;
  logic         eoc_s[4], eq_s[4], gr_s[4], lr_s[4];
`ifdef COMPARATOR_MINMAX_EN
  logic [N-1:0] min_s[4], max_s[4];
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0]   prev_flags = 3'b000;
  logic [N-1:0] prev_min = '0, prev_max = '0;

  always #5 clock = ~clock;

  b2_serial_integer_comparator #(.N(N), .K(K)) dut (
    .clock(clock), .reset_(reset_), .soc(soc), .eoc(eoc), .signed_mode(signed_mode),
    .x(x), .y(y), .flag_eq(flag_eq), .flag_gr(flag_gr), .flag_lr(flag_lr)
`ifdef COMPARATOR_MINMAX_EN
    , .min_out(min_out), .max_out(max_out)
`endif
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    b2_serial_integer_comparator #(.N(N), .K(1 << g)) dut_k (
      .clock(clock), .reset_(reset_), .soc(soc_s), .eoc(eoc_s[g]), .signed_mode(sm_s),
      .x(x_s), .y(y_s), .flag_eq(eq_s[g]), .flag_gr(gr_s[g]), .flag_lr(lr_s[g])
`ifdef COMPARATOR_MINMAX_EN
      , .min_out(min_s[g]), .max_out(max_s[g])
`endif
    );
  end

  // Reference: {eq, gr, lr} from ordinary signed/unsigned comparison.
  function automatic logic [2:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    logic lt, eq;
    lt = sm ? ($signed(a) < $signed(b)) : (a < b);
    eq = (a == b);
    return {eq, ~eq & ~lt, lt};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b, input logic sm);
    logic [2:0] exp, at_d, before_d;
    int n;
    exp = ref_flags(a, b, sm);
    x = a; y = b; signed_mode = sm; soc = 1'b1;
    tick();
    soc = 1'b0;
    checks++; if (eoc !== 1'b0) begin errors++; $display("FAIL %s eoc_fall got %b want 0", name, eoc); end
    checks++; if ({flag_eq, flag_gr, flag_lr} !== prev_flags) begin
      errors++; $display("FAIL %s hold_at_start got %b want %b", name, {flag_eq, flag_gr, flag_lr}, prev_flags); end
    n = 0; at_d = 3'bxxx; before_d = prev_flags;
    while (eoc !== 1'b1 && n < 64) begin
      tick();
      n++;
      if (n == D - 1) before_d = {flag_eq, flag_gr, flag_lr};
      if (n == D)     at_d     = {flag_eq, flag_gr, flag_lr};
    end
    checks++; if (n != D + 1) begin errors++; $display("FAIL %s eoc_latency got %0d want %0d", name, n, D + 1); end
    checks++; if (before_d !== prev_flags) begin
      errors++; $display("FAIL %s early_flags got %b want %b", name, before_d, prev_flags); end
    checks++; if (at_d !== exp) begin errors++; $display("FAIL %s flags_at_T0+D got %b want %b", name, at_d, exp); end
    checks++; if ({flag_eq, flag_gr, flag_lr} !== exp) begin
      errors++; $display("FAIL %s flags got %b want %b (x=%h y=%h s=%b)", name, {flag_eq, flag_gr, flag_lr}, exp, a, b, sm); end
`ifdef COMPARATOR_MINMAX_EN
    prev_min = exp[0] ? a : b;
    prev_max = exp[0] ? b : a;
    checks++; if (min_out !== prev_min || max_out !== prev_max) begin
      errors++; $display("FAIL %s minmax got %h/%h want %h/%h", name, min_out, max_out, prev_min, prev_max); end
`endif
    prev_flags = exp;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    #1;
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL reset_eoc got %b want 1", eoc); end
    checks++; if ({flag_eq, flag_gr, flag_lr} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {flag_eq, flag_gr, flag_lr}); end
`ifdef COMPARATOR_MINMAX_EN
    checks++; if (min_out !== '0 || max_out !== '0) begin
      errors++; $display("FAIL reset_minmax got %h/%h want 0/0", min_out, max_out); end
`endif
    #10 reset_ = 1'b1;
    tick();
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL idle_after_reset eoc got %b want 1", eoc); end
  endtask

  task automatic test_directed();
    run_op("eq_5a",        8'h5A, 8'h5A, 1'b0);
    run_op("signed_m1_1",  8'hFF, 8'h01, 1'b1);
    run_op("unsigned_ff_1",8'hFF, 8'h01, 1'b0);
    run_op("signed_80_7f", 8'h80, 8'h7F, 1'b1);
    run_op("signed_7f_80", 8'h7F, 8'h80, 1'b1);
    run_op("unsign_80_7f", 8'h80, 8'h7F, 1'b0);
    run_op("zero_zero",    8'h00, 8'h00, 1'b1);
    run_op("msb_digit_lt", 8'h3F, 8'h40, 1'b0);
  endtask

  task automatic test_handshake();
    x = 8'd3; y = 8'd9; signed_mode = 1'b0; soc = 1'b1;
    tick();
    x = 8'd200; y = 8'd1; signed_mode = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++; if (eoc !== 1'b0) begin errors++; $display("FAIL hs_eoc_low cycle %0d got %b want 0", c, eoc); end
      if (c == D) begin
        checks++; if ({flag_eq, flag_gr, flag_lr} !== 3'b001) begin
          errors++; $display("FAIL hs_flags got %b want 001", {flag_eq, flag_gr, flag_lr}); end
      end
    end
    soc = 1'b0;
    tick();
    checks++; if (eoc !== 1'b1) begin errors++; $display("FAIL hs_eoc_rise got %b want 1", eoc); end
    tick();
    checks++; if (eoc !== 1'b1 || {flag_eq, flag_gr, flag_lr} !== 3'b001) begin
      errors++; $display("FAIL hs_idle_hold got eoc=%b flags=%b want 1/001", eoc, {flag_eq, flag_gr, flag_lr}); end
    prev_flags = 3'b001;
`ifdef COMPARATOR_MINMAX_EN
    prev_min = 8'd3; prev_max = 8'd9;
    checks++; if (min_out !== prev_min || max_out !== prev_max) begin
      errors++; $display("FAIL hs_minmax got %h/%h want 03/09", min_out, max_out); end
`endif
  endtask

  task automatic test_reset_mid();
    x = 8'h22; y = 8'h11; signed_mode = 1'b0; soc = 1'b1;
    tick();
    soc = 1'b0;
    tick();
    #2 reset_ = 1'b0;
    #1;
    checks++; if (eoc !== 1'b1 || {flag_eq, flag_gr, flag_lr} !== 3'b000) begin
      errors++; $display("FAIL mid_reset got eoc=%b flags=%b want 1/000", eoc, {flag_eq, flag_gr, flag_lr}); end
`ifdef COMPARATOR_MINMAX_EN
    checks++; if (min_out !== '0 || max_out !== '0) begin
      errors++; $display("FAIL mid_reset_minmax got %h/%h want 0/0", min_out, max_out); end
`endif
    #2 reset_ = 1'b1;
    prev_flags = 3'b000;
    prev_min = '0; prev_max = '0;
    tick();
    run_op("after_reset", 8'h10, 8'h0F, 1'b0);
  endtask

  task automatic test_minmax();
    run_op("minmax_f0_05", 8'hF0, 8'h05, 1'b1);
`ifdef COMPARATOR_MINMAX_EN
    checks++; if (min_out !== 8'hF0 || max_out !== 8'h05) begin
      errors++; $display("FAIL minmax_direct got %h/%h want f0/05", min_out, max_out); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = (i % 5 == 0) ? a : N'($urandom);
      run_op("random", a, b, 1'($urandom));
    end
  endtask

  task automatic test_sweep();
    for (int it = 0; it < 12; it++) begin
      int done[4];
      int lat;
      logic [2:0] exp;
      x_s = N'($urandom); y_s = N'($urandom); sm_s = 1'($urandom);
      if (it == 0) y_s = x_s;
      if (it == 1) begin x_s = 8'h80; y_s = 8'h7F; sm_s = 1'b1; end
      exp = ref_flags(x_s, y_s, sm_s);
      for (int g = 0; g < 4; g++) done[g] = -1;
      soc_s = 1'b1;
      tick();
      soc_s = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        for (int g = 0; g < 4; g++) if (done[g] < 0 && eoc_s[g] === 1'b1) done[g] = c;
        if (done[0] >= 0 && done[1] >= 0 && done[2] >= 0 && done[3] >= 0) break;
      end
      for (int g = 0; g < 4; g++) begin
        lat = (N >> g) + 1;
        checks++; if (done[g] != lat) begin
          errors++; $display("FAIL sweep_latency K=%0d got %0d want %0d", 1 << g, done[g], lat); end
        checks++; if ({eq_s[g], gr_s[g], lr_s[g]} !== exp) begin
          errors++; $display("FAIL sweep_flags K=%0d got %b want %b (x=%h y=%h s=%b)",
                             1 << g, {eq_s[g], gr_s[g], lr_s[g]}, exp, x_s, y_s, sm_s); end
`ifdef COMPARATOR_MINMAX_EN
        checks++; if (min_s[g] !== (exp[0] ? x_s : y_s) || max_s[g] !== (exp[0] ? y_s : x_s)) begin
          errors++; $display("FAIL sweep_minmax K=%0d got %h/%h", 1 << g, min_s[g], max_s[g]); end
`endif
      end
    end
  endtask

  initial begin
    reset_ = 1'b0; soc = 1'b0; signed_mode = 1'b0; x = '0; y = '0;
    soc_s = 1'b0; sm_s = 1'b0; x_s = '0; y_s = '0;
    #2;
    test_reset();
    test_directed();
    test_handshake();
    test_reset_mid();
    test_minmax();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
